// File: rtl/ctrl_pipe_hazard_if.sv
// Bundle between the decode stage and the pipeline control/hazard block:
// the decode control word and ZeroE in, the stage controls and hazard selects out.
interface ctrl_pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
);
  logic              RegWriteD;
  logic              ALUSrcD;
  logic              MemWriteD;
  logic [1:0]        ResultSrcD;
  logic              BranchD;
  logic              JumpD;
  logic [ALUC_W-1:0] ALUControlD;
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] RdD;
  logic              ZeroE;

  logic              ALUSrcE;
  logic [ALUC_W-1:0] ALUControlE;
  logic              PCSrcE;
  logic              MemWriteM;
  logic              RegWriteW;
  logic [1:0]        ResultSrcW;
  logic [REG_AW-1:0] RdW;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;

  modport master (
    output RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, JumpD,
           ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
    input  ALUSrcE, ALUControlE, PCSrcE, MemWriteM, RegWriteW, ResultSrcW,
           RdW, ForwardAE, ForwardBE, StallF, StallD, FlushD
  );

  modport slave (
    input  RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, JumpD,
           ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
    output ALUSrcE, ALUControlE, PCSrcE, MemWriteM, RegWriteW, ResultSrcW,
           RdW, ForwardAE, ForwardBE, StallF, StallD, FlushD
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) for a 5-stage RISC-V core,
// with EX branch resolution, load-use stall/flush and EX forwarding selects.
module ctrl_pipe_hazard #(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
) (
  input logic               clk,
  input logic               rst,
  ctrl_pipe_hazard_if.slave bus
);

  typedef struct packed {
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic [1:0]        result_src;
    logic              branch;
    logic              jump;
    logic [ALUC_W-1:0] alu_control;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
  } mem_wb_t;

  id_ex_t  id_ex_reg;
  id_ex_t  id_ex_next;
  ex_mem_t ex_mem_reg;
  mem_wb_t mem_wb_reg;

  logic lw_stall;
  logic pc_src;

  // Only ResultSrc=01 is a load; 11 must not stall.
  always_comb begin
    lw_stall = (id_ex_reg.result_src == 2'b01) && (id_ex_reg.rd != '0) &&
               ((id_ex_reg.rd == bus.Rs1D) || (id_ex_reg.rd == bus.Rs2D));
    pc_src   = (id_ex_reg.branch && bus.ZeroE) || id_ex_reg.jump;
  end

  // A stalled or squashed decode slot enters EX as an all-zero bubble.
  always_comb begin
    id_ex_next = '0;
    if (!(lw_stall || pc_src)) begin
      id_ex_next.reg_write   = bus.RegWriteD;
      id_ex_next.alu_src     = bus.ALUSrcD;
      id_ex_next.mem_write   = bus.MemWriteD;
      id_ex_next.result_src  = bus.ResultSrcD;
      id_ex_next.branch      = bus.BranchD;
      id_ex_next.jump        = bus.JumpD;
      id_ex_next.alu_control = bus.ALUControlD;
      id_ex_next.rs1         = bus.Rs1D;
      id_ex_next.rs2         = bus.Rs2D;
      id_ex_next.rd          = bus.RdD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_reg  <= '0;
      ex_mem_reg <= '0;
      mem_wb_reg <= '0;
    end else begin
      id_ex_reg             <= id_ex_next;
      ex_mem_reg.reg_write  <= id_ex_reg.reg_write;
      ex_mem_reg.mem_write  <= id_ex_reg.mem_write;
      ex_mem_reg.result_src <= id_ex_reg.result_src;
      ex_mem_reg.rd         <= id_ex_reg.rd;
      mem_wb_reg.reg_write  <= ex_mem_reg.reg_write;
      mem_wb_reg.result_src <= ex_mem_reg.result_src;
      mem_wb_reg.rd         <= ex_mem_reg.rd;
    end
  end

  // One forwarding unit per EX source operand; MEM wins over WB, x0 never forwards.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [REG_AW-1:0] rs_e;
      logic [1:0]        sel;
      assign rs_e = (gi == 0) ? id_ex_reg.rs1 : id_ex_reg.rs2;
      always_comb begin
        sel = 2'b00;
        if (ex_mem_reg.reg_write && (ex_mem_reg.rd != '0) && (ex_mem_reg.rd == rs_e))
          sel = 2'b10;
        else if (mem_wb_reg.reg_write && (mem_wb_reg.rd != '0) && (mem_wb_reg.rd == rs_e))
          sel = 2'b01;
      end
    end
  endgenerate

  assign bus.ALUSrcE     = id_ex_reg.alu_src;
  assign bus.ALUControlE = id_ex_reg.alu_control;
  assign bus.PCSrcE      = pc_src;
  assign bus.MemWriteM   = ex_mem_reg.mem_write;
  assign bus.RegWriteW   = mem_wb_reg.reg_write;
  assign bus.ResultSrcW  = mem_wb_reg.result_src;
  assign bus.RdW         = mem_wb_reg.rd;
  assign bus.ForwardAE   = g_fwd[0].sel;
  assign bus.ForwardBE   = g_fwd[1].sel;
  assign bus.StallF      = lw_stall;
  assign bus.StallD      = lw_stall;
  assign bus.FlushD      = pc_src;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ctrl_pipe_hazard;

  logic clk;
  logic rst;

  ctrl_pipe_hazard_if #(.REG_AW(5), .ALUC_W(3)) bus ();

  ctrl_pipe_hazard #(.REG_AW(5), .ALUC_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    F_ALUSRC, F_ALUC, F_PCSRC, F_MWM, F_RWW, F_RSW, F_RDW,
    F_FA, F_FB, F_SF, F_SD, F_FD, F_ALL
  } field_e;

  typedef struct {
    int          cyc;
    field_e      f;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] act(field_e f);
    case (f)
      F_ALUSRC: return 32'(bus.ALUSrcE);
      F_ALUC:   return 32'(bus.ALUControlE);
      F_PCSRC:  return 32'(bus.PCSrcE);
      F_MWM:    return 32'(bus.MemWriteM);
      F_RWW:    return 32'(bus.RegWriteW);
      F_RSW:    return 32'(bus.ResultSrcW);
      F_RDW:    return 32'(bus.RdW);
      F_FA:     return 32'(bus.ForwardAE);
      F_FB:     return 32'(bus.ForwardBE);
      F_SF:     return 32'(bus.StallF);
      F_SD:     return 32'(bus.StallD);
      F_FD:     return 32'(bus.FlushD);
      default:  return 32'({bus.ALUSrcE, bus.ALUControlE, bus.PCSrcE, bus.MemWriteM,
                            bus.RegWriteW, bus.ResultSrcW, bus.RdW, bus.ForwardAE,
                            bus.ForwardBE, bus.StallF, bus.StallD, bus.FlushD});
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_mon = sb.pop_front();
      checks++;
      if (e_mon.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d",
                 e_mon.name, e_mon.cyc, cyc);
      end else if (act(e_mon.f) !== e_mon.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %0h expected %0h",
                 e_mon.name, cyc, act(e_mon.f), e_mon.val);
      end else begin
        $display("ok   %s (cycle %0d): %0h", e_mon.name, cyc, e_mon.val);
      end
    end
  end

  task automatic chk(input field_e f, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.f    = f;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drv(input logic rw, input logic as, input logic mw, input logic [1:0] rs,
                     input logic br, input logic jp, input logic [2:0] aluc,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic ze);
    bus.RegWriteD   = rw;
    bus.ALUSrcD     = as;
    bus.MemWriteD   = mw;
    bus.ResultSrcD  = rs;
    bus.BranchD     = br;
    bus.JumpD       = jp;
    bus.ALUControlD = aluc;
    bus.Rs1D        = rs1;
    bus.Rs2D        = rs2;
    bus.RdD         = rd;
    bus.ZeroE       = ze;
  endtask

  task automatic nop();
    drv(0, 0, 0, 2'd0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic rand_d();
    drv(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
        1'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
        1'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rand_d();

    // Reset held with random decode words
    for (int i = 0; i < 4; i++) begin
      tick(); rand_d(); chk(F_ALL, 0, "reset_all_zero");
    end
    tick(); rst = 1'b1; nop(); chk(F_ALL, 0, "post_reset_all_zero");

    // Latency of a single word
    tick(); drv(1, 1, 0, 2'd0, 0, 0, 3'd2, 5'd1, 5'd2, 5'd3, 0); chk(F_RWW, 0, "lat_rww_c0");
    tick(); nop(); chk(F_ALUSRC, 1, "lat_alusrc_e"); chk(F_ALUC, 2, "lat_aluc_e");
    chk(F_RWW, 0, "lat_rww_c1");
    tick(); nop(); chk(F_RWW, 0, "lat_rww_c2");
    tick(); nop(); chk(F_RWW, 1, "lat_rww_c3"); chk(F_RDW, 3, "lat_rdw");
    chk(F_RSW, 0, "lat_rsw");

    // Back-to-back ALU ops
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5, 0);
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd6, 5'd5, 5'd6, 5'd8, 0); chk(F_SF, 0, "b2b_nostall");
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd1, 5'd6, 5'd5, 5'd10, 0);
    chk(F_FA, 2, "b2b_fwdA_mem"); chk(F_FB, 0, "b2b_fwdB_none"); chk(F_ALUC, 6, "b2b_aluc");
    tick(); nop(); chk(F_FB, 1, "b2b_fwdB_wb"); chk(F_FA, 0, "b2b_fwdA_none");
    tick(); nop();
    tick(); nop();

    // Load-use: one stall cycle, then a bubble, then WB forwarding
    tick(); drv(1, 1, 0, 2'd1, 0, 0, 3'd0, 5'd2, 5'd0, 5'd7, 0);
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd7, 5'd3, 5'd7, 5'd9, 0);
    chk(F_SF, 1, "lu_stallF"); chk(F_SD, 1, "lu_stallD"); chk(F_FD, 0, "lu_noflush");
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd7, 5'd3, 5'd7, 5'd9, 0);
    chk(F_SF, 0, "lu_stall_one_cycle"); chk(F_ALUC, 0, "lu_bubble_aluc");
    chk(F_ALUSRC, 0, "lu_bubble_alusrc");
    tick(); nop(); chk(F_FB, 1, "lu_fwdB_wb"); chk(F_ALUC, 7, "lu_consumer_e");
    chk(F_RWW, 1, "lu_lw_rww"); chk(F_RDW, 7, "lu_lw_rdw"); chk(F_RSW, 1, "lu_lw_rsw");
    tick(); nop(); chk(F_RWW, 0, "lu_bubble_wb");
    tick(); nop(); chk(F_RWW, 1, "lu_consumer_rww"); chk(F_RDW, 9, "lu_consumer_rdw");

    // Branch taken
    tick(); drv(0, 0, 0, 2'd0, 1, 0, 3'd1, 5'd1, 5'd2, 5'd0, 0);
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd3, 5'd0, 5'd0, 5'd12, 1);
    chk(F_PCSRC, 1, "br_taken_pcsrc"); chk(F_FD, 1, "br_taken_flush"); chk(F_SF, 0, "br_taken_nostall");
    tick(); nop(); chk(F_ALUC, 0, "br_bubble_aluc"); chk(F_PCSRC, 0, "br_bubble_pcsrc");
    chk(F_FD, 0, "br_bubble_noflush");
    tick(); nop();
    tick(); nop(); chk(F_RWW, 0, "br_squashed_wb");

    // Branch not taken
    tick(); drv(0, 0, 0, 2'd0, 1, 0, 3'd1, 5'd1, 5'd2, 5'd0, 0);
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd3, 5'd0, 5'd0, 5'd13, 0);
    chk(F_PCSRC, 0, "br_nt_pcsrc"); chk(F_FD, 0, "br_nt_noflush");
    tick(); nop(); chk(F_ALUC, 3, "br_nt_next_e");
    tick(); nop();
    tick(); nop(); chk(F_RWW, 1, "br_nt_rww"); chk(F_RDW, 13, "br_nt_rdw");

    // Jump ignores ZeroE
    tick(); drv(1, 0, 0, 2'd2, 0, 1, 3'd0, 5'd0, 5'd0, 5'd1, 0);
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd5, 5'd0, 5'd0, 5'd14, 0);
    chk(F_PCSRC, 1, "jmp_pcsrc"); chk(F_FD, 1, "jmp_flush");
    tick(); nop(); chk(F_ALUC, 0, "jmp_bubble_aluc");

    // x0 guard
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd2, 5'd0, 5'd0, 5'd0, 0);
    tick(); drv(1, 1, 0, 2'd1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0); chk(F_SF, 0, "x0_nostall_a");
    tick(); nop(); chk(F_SF, 0, "x0_load_nostall"); chk(F_FA, 0, "x0_nofwd_mem");
    tick(); nop(); chk(F_FA, 0, "x0_nofwd_a"); chk(F_FB, 0, "x0_nofwd_b");

    // MEM over WB priority
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd9, 0);
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd0, 5'd3, 5'd4, 5'd9, 0);
    tick(); drv(0, 0, 0, 2'd0, 0, 0, 3'd0, 5'd9, 5'd9, 5'd0, 0); chk(F_SF, 0, "prio_nostall");
    tick(); nop(); chk(F_FA, 2, "prio_fwdA_mem"); chk(F_FB, 2, "prio_fwdB_mem");

    // ResultSrc=11 is not a load
    tick(); drv(1, 0, 0, 2'd3, 0, 0, 3'd0, 5'd0, 5'd0, 5'd4, 0);
    tick(); drv(0, 0, 0, 2'd0, 0, 0, 3'd0, 5'd4, 5'd4, 5'd0, 0);
    chk(F_SF, 0, "rs11_nostallF"); chk(F_SD, 0, "rs11_nostallD");

    // Simultaneous load-use and jump
    tick(); drv(1, 0, 0, 2'd1, 0, 1, 3'd4, 5'd0, 5'd0, 5'd6, 0);
    tick(); drv(1, 0, 0, 2'd0, 0, 0, 3'd2, 5'd6, 5'd0, 5'd11, 0);
    chk(F_SF, 1, "both_stallF"); chk(F_SD, 1, "both_stallD"); chk(F_FD, 1, "both_flush");
    chk(F_PCSRC, 1, "both_pcsrc");
    tick(); nop(); chk(F_ALUC, 0, "both_bubble_aluc"); chk(F_PCSRC, 0, "both_bubble_pcsrc");
    chk(F_SF, 0, "both_bubble_nostall");

    // Asynchronous reset mid-stream while MemWriteM=1
    tick(); drv(0, 1, 1, 2'd0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd0, 0);
    tick(); drv(1, 1, 1, 2'd0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd15, 0);
    tick(); nop(); chk(F_MWM, 1, "ar_mwm_before");
    tick(); nop(); #1 rst = 1'b0; chk(F_MWM, 0, "ar_mwm_async"); chk(F_ALL, 0, "ar_all_async");
    tick(); nop(); chk(F_ALL, 0, "ar_all_held");
    tick(); rst = 1'b1; nop(); chk(F_RWW, 0, "ar_refill_rww0");
    tick(); chk(F_RWW, 0, "ar_refill_rww1"); chk(F_MWM, 0, "ar_refill_mwm");
    tick(); chk(F_RWW, 0, "ar_refill_rww2");
    tick(); chk(F_RWW, 0, "ar_refill_rww3");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Consumer of the decode-stage control word. Carries RegWrite/ALUSrc/MemWrite/ResultSrc/ALUControl/branch/Jump and the register addresses through the ID/EX, EX/MEM and MEM/WB stage registers.
- Resolves branch/jump in EX and produces PCSrcE.
- Detects load-use hazards and produces stall/flush controls.
- Produces the EX-stage forwarding selects for the 5-stage RISC-V pipeline.

Parameters:
- REG_AW, 5, register address width.
- ALUC_W, 3, ALUControl width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 clears all state).
- RegWriteD  in  1  decode control word.
- ALUSrcD  in  1  decode control word.
- MemWriteD  in  1  decode control word.
- ResultSrcD  in  2  00=ALU, 01=memory, 10=PC+4.
- BranchD  in  1  conditional branch.
- JumpD  in  1  jal/jalr.
- ALUControlD  in  ALUC_W  ALU operation.
- Rs1D, Rs2D, RdD  in  REG_AW  decode register addresses.
- ZeroE  in  1  ALU zero flag of the instruction currently in EX.
- ALUSrcE  out  1  EX control.
- ALUControlE  out  ALUC_W  EX control.
- PCSrcE  out  1  take branch/jump target.
- MemWriteM  out  1  MEM control.
- RegWriteW  out  1  WB control.
- ResultSrcW  out  2  WB control.
- RdW  out  REG_AW  WB destination.
- ForwardAE, ForwardBE  out  2  00=regfile, 01=WB result, 10=MEM ALU result.
- StallF, StallD  out  1  hold PC and the IF/ID register.
- FlushD  out  1  clear the IF/ID register.

Behaviour:
- Reset (rst=0, asynchronous): all E/M/W stage registers clear to 0. Resulting outputs: every control output 0, Rd*=0, PCSrcE=0, ForwardAE/BE=00, StallF/StallD/FlushD=0.
- Reset deasserted mid-stream: the pipeline refills from bubbles; no spurious RegWriteW or MemWriteM.
- Stage registers: ID/EX captures the D control word plus Rs1D/Rs2D/RdD on every rising edge. EX/MEM captures from EX, and MEM/WB captures from MEM, unconditionally. EX/MEM/WB never stall.
- Latency: a control word applied in cycle n appears at the E outputs in cycle n+1, MemWriteM in n+2, and RegWriteW/ResultSrcW/RdW in n+3.
- PCSrcE = (BranchE & ZeroE) | JumpE. This is combinational from registered state and ZeroE.
- Load-use hazard: lwStall = (ResultSrcE==01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
  - StallF = StallD = lwStall.
- FlushD = PCSrcE.
- ID/EX bubble: when lwStall | PCSrcE, the next edge loads ID/EX with all-zero control, Rs1/Rs2/Rd = 0.
- Forwarding for Rs1E:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - MEM has priority over WB when both match. ForwardBE uses the same rule on Rs2E.
  - x0 never forwards.
- Simultaneous lwStall and PCSrcE: StallF, StallD and FlushD are all asserted, and ID/EX gets a bubble. The IF/ID register gives flush priority over stall.
- A flushed or bubbled slot has RegWrite=0 and MemWrite=0, so it never triggers forwarding or hazards downstream.
- ResultSrc=11 is treated as non-load; it never causes a stall.

Test Plan:
- Reset: hold rst=0 with random D inputs, then release. Required: all outputs 0 while in reset; the first nonzero RegWriteW appears 3 edges after the first D word with RegWriteD=1.
- Back-to-back ALU ops: add x5 (RdD=5, RegWriteD=1), then next cycle an op with Rs1D=5. Required: ForwardAE=10 in the consumer's EX cycle. A third-cycle consumer with Rs2D=5 gets ForwardBE=01.
- Load-use: lw x7 (ResultSrcD=01, RdD=7), followed by an op with Rs2D=7. Required: StallF=StallD=1 for exactly 1 cycle; the following EX cycle shows a bubble (ALUControlE=0, RegWrite=0); then ForwardBE=01.
- Branch: BranchD=1 in EX with ZeroE=1. Required: PCSrcE=1 and FlushD=1 that cycle, and ID/EX holds a bubble next cycle. Repeat with ZeroE=0: PCSrcE=0 and no flush.
- x0 guard and priority: writes to RdD=0 followed by consumers with Rs1D=0 give ForwardAE=00 and no stall. Both MEM and WB targeting x9 with Rs1E=9 gives 10.
- Async reset mid-stream: pull rst low between edges while MemWriteM=1. Required: MemWriteM drops to 0 immediately, without waiting for a clock edge.
